serial_link: RTL and testbench



---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_edge_det.sv | 50 +++++
 rtl/serial_link.sv | 171 +++++++++++++++++
 tb/tb_serial_link.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and types for the Game Boy serial port
// (SB at FF01, SC at FF02). Imported by serial_edge_det and serial_link.
package serial_pkg;
  // SC register bit positions
  localparam int SC_START = 7;
  localparam int SC_CLK   = 0;

  // Default transfer length and SC[6:1] read-back value
  localparam int         SER_BITS      = 8;
  localparam logic [5:0] SER_SC_UNUSED = 6'b111111;

  // Reset values for the visible state
  localparam logic [7:0] SB_RST   = 8'h00;
  localparam logic       SCK_RST  = 1'b1;  // serial clock idles high
  localparam logic       SOUT_RST = 1'b1;  // serial data idles high

  // Transfer state, decoded from SC
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER_INT = 2'd1,
    XFER_EXT = 2'd2
  } state_e;
endpackage

// File: rtl/serial_edge_det.sv
// serial_edge_det: optional 2-flop synchronizer followed by a single
// edge-detect register.
//   clk, reset : system clock, synchronous active-high reset
//   d          : raw input level
//   lvl        : (synchronized) level presented to the edge detector
//   rise, fall : one-cycle pulses, combinational from lvl vs. its previous
//                value, so the consuming logic acts on the next clk edge
// Parameters: SYNC selects the 2-flop synchronizer; RST_VAL is the idle
// level, used as reset value so no false edge appears after reset.
module serial_edge_det
  import serial_pkg::*;
#(
  parameter bit SYNC    = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic prev;

  generate
    if (SYNC) begin : g_sync
      logic s1, s2;
      always_ff @(posedge clk) begin
        if (reset) begin
          s1 <= RST_VAL;
          s2 <= RST_VAL;
        end else begin
          s1 <= d;
          s2 <= s1;
        end
      end
      assign lvl = s2;
    end else begin : g_nosync
      assign lvl = d;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) prev <= RST_VAL;
    else       prev <= lvl;
  end

  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;
endmodule

// File: rtl/serial_link.sv
// serial_link: Game Boy serial port, 8-bit shift transfer with internal
// (8192 Hz, derived from the 16384 Hz LFO) or external serial clock.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   d_in / d_out / d_oe   : internal data bus write value, read data, read enable
//   sb_read, n_sb_write   : SB read strobe, SB write strobe (active-low)
//   sc_read, sc_write     : SC read / write strobes
//   lfo_16384Hz           : divider tap (level), rising edges pace XFER_INT
//   sck_in/sck_out/sck_oe : serial clock pin in, internal clock out, drive enable
//   sin, sout             : serial data in / out
//   int_serial            : one-cycle transfer-complete pulse
// Build option: define SERIAL_SCK_SYNC_EN to pass sck_in and sin through a
// 2-flop synchronizer (edges acted on 3 clk after the pin change). Without it
// the pins are assumed synchronous to clk (1 clk latency).
module serial_link
  import serial_pkg::*;
#(
  parameter int         BITS      = SER_BITS,
  parameter logic [5:0] SC_UNUSED = SER_SC_UNUSED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic       sb_read,
  input  logic       n_sb_write,
  input  logic       sc_read,
  input  logic       sc_write,
  input  logic       lfo_16384Hz,
  input  logic       sck_in,
  output logic       sck_out,
  output logic       sck_oe,
  input  logic       sin,
  output logic       sout,
  output logic       int_serial
);
  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);

`ifdef SERIAL_SCK_SYNC_EN
  localparam bit PIN_SYNC = 1'b1;
`else
  localparam bit PIN_SYNC = 1'b0;
`endif

  // The LFO is on-chip and already synchronous: never synchronized.
  logic lfo_rise, lfo_fall_unused, lfo_lvl_unused;
  logic sck_rise, sck_fall, sck_lvl_unused;
  logic sin_s, sin_rise_unused, sin_fall_unused;

  serial_edge_det #(.SYNC(1'b0), .RST_VAL(1'b0)) u_lfo_edge (
    .clk(clk), .reset(reset), .d(lfo_16384Hz),
    .lvl(lfo_lvl_unused), .rise(lfo_rise), .fall(lfo_fall_unused)
  );

  serial_edge_det #(.SYNC(PIN_SYNC), .RST_VAL(1'b1)) u_sck_edge (
    .clk(clk), .reset(reset), .d(sck_in),
    .lvl(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  // sin shares the same synchronizer depth so data stays aligned with sck_in.
  serial_edge_det #(.SYNC(PIN_SYNC), .RST_VAL(1'b1)) u_sin_sync (
    .clk(clk), .reset(reset), .d(sin),
    .lvl(sin_s), .rise(sin_rise_unused), .fall(sin_fall_unused)
  );

  // Architectural state
  logic [7:0]    sb,         sb_n;
  logic          sc_start,   sc_start_n;
  logic          sc_clk_int, sc_clk_int_n;
  logic [CW-1:0] bit_cnt,    bit_cnt_n;
  logic          half,       half_n;
  logic          sout_q,     sout_n;
  logic          sck_q,      sck_n;
  logic          int_q,      int_n;
  state_e        state;

  assign state = !sc_start  ? IDLE :
                 sc_clk_int ? XFER_INT : XFER_EXT;

  always_ff @(posedge clk) begin
    if (reset) begin
      sb         <= SB_RST;
      sc_start   <= 1'b0;
      sc_clk_int <= 1'b0;
      bit_cnt    <= '0;
      half       <= 1'b0;
      sout_q     <= SOUT_RST;
      sck_q      <= SCK_RST;
      int_q      <= 1'b0;
    end else begin
      sb         <= sb_n;
      sc_start   <= sc_start_n;
      sc_clk_int <= sc_clk_int_n;
      bit_cnt    <= bit_cnt_n;
      half       <= half_n;
      sout_q     <= sout_n;
      sck_q      <= sck_n;
      int_q      <= int_n;
    end
  end

  always_comb begin
    sb_n         = sb;
    sc_start_n   = sc_start;
    sc_clk_int_n = sc_clk_int;
    bit_cnt_n    = bit_cnt;
    half_n       = half;
    sout_n       = sout_q;
    sck_n        = sck_q;
    int_n        = 1'b0;

    unique case (state)
      XFER_INT: begin
        if (lfo_rise) begin
          half_n = ~half;
          if (!half) begin
            sck_n  = 1'b0;
            sout_n = sb[7];
          end else begin
            sck_n     = 1'b1;
            sb_n      = {sb[6:0], sin_s};
            bit_cnt_n = bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_n  = '0;
              sc_start_n = 1'b0;
              int_n      = 1'b1;
            end
          end
        end
      end
      XFER_EXT: begin
        if (sck_fall) sout_n = sb[7];
        if (sck_rise) begin
          sb_n      = {sb[6:0], sin_s};
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n  = '0;
            sc_start_n = 1'b0;
            int_n      = 1'b1;
          end
        end
      end
      default: ;  // IDLE: pin and LFO edges ignored
    endcase

    // CPU writes take priority over a shift in the same cycle.
    if (!n_sb_write) sb_n = d_in;
    if (sc_write) begin
      sc_start_n   = d_in[SC_START];
      sc_clk_int_n = d_in[SC_CLK];
      bit_cnt_n    = '0;
      half_n       = 1'b0;
      sck_n        = 1'b1;
      int_n        = 1'b0;
    end
  end

  always_comb begin
    d_out = 8'h00;
    if (sb_read)      d_out = sb;
    else if (sc_read) d_out = {sc_start, SC_UNUSED, sc_clk_int};
  end

  assign d_oe       = sb_read | sc_read;
  assign sck_out    = sck_q;
  assign sck_oe     = sc_clk_int;
  assign sout       = sout_q;
  assign int_serial = int_q;
endmodule

// File: tb/tb_serial_link.sv
module tb_serial_link;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_oe;
  logic       sb_read = 1'b0, n_sb_write = 1'b1, sc_read = 1'b0, sc_write = 1'b0;
  logic       lfo_16384Hz = 1'b0, sck_in = 1'b1, sin = 1'b1;
  logic       sck_out, sck_oe, sout, int_serial;

  int pass_cnt = 0, total_cnt = 0;
  int int_cnt = 0, int_hi = 0;
  logic int_prev = 1'b0;

  serial_link dut (
    .clk(clk), .reset(reset), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    .sb_read(sb_read), .n_sb_write(n_sb_write), .sc_read(sc_read),
    .sc_write(sc_write), .lfo_16384Hz(lfo_16384Hz), .sck_in(sck_in),
    .sck_out(sck_out), .sck_oe(sck_oe), .sin(sin), .sout(sout),
    .int_serial(int_serial)
  );

  always #5 clk = ~clk;

  // Interrupt monitor: pulses counted by rising edge, width by high cycles.
  always @(negedge clk) begin
    int_prev <= int_serial;
    if (int_serial) int_hi <= int_hi + 1;
    if (int_serial && !int_prev) int_cnt <= int_cnt + 1;
  end

  typedef struct {
    string      name;
    logic       sb_rd, sb_wr, sc_rd, sc_wr;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_oe, exp_sck_oe;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_sb(input logic [7:0] v);
    n_sb_write = 1'b0; d_in = v; cyc(1); n_sb_write = 1'b1;
  endtask

  task automatic wr_sc(input logic [7:0] v);
    sc_write = 1'b1; d_in = v; cyc(1); sc_write = 1'b0;
  endtask

  task automatic rd_sb(output logic [7:0] v);
    sb_read = 1'b1; #2 v = d_out; sb_read = 1'b0;
  endtask

  task automatic rd_sc(output logic [7:0] v);
    sc_read = 1'b1; #2 v = d_out; sc_read = 1'b0;
  endtask

  task automatic lfo_pulse();
    lfo_16384Hz = 1'b1; cyc(3); lfo_16384Hz = 1'b0; cyc(3);
  endtask

  task automatic set_vec(input int i, input string nm, input logic sbr, input logic sbw,
                         input logic scr, input logic scw, input logic [7:0] din,
                         input logic [7:0] dout, input logic oe, input logic soe);
    vecs[i].name = nm; vecs[i].sb_rd = sbr; vecs[i].sb_wr = sbw;
    vecs[i].sc_rd = scr; vecs[i].sc_wr = scw; vecs[i].din = din;
    vecs[i].exp_dout = dout; vecs[i].exp_oe = oe; vecs[i].exp_sck_oe = soe;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] pat;
    int base;

    //          name        sbr  sbw  scr  scw  din    dout   oe   sck_oe
    set_vec(0,  "sb_wr_5a", 1'b0,1'b1,1'b0,1'b0,8'h5A, 8'h00, 1'b0,1'b0);
    set_vec(1,  "sb_rd_5a", 1'b1,1'b0,1'b0,1'b0,8'h00, 8'h5A, 1'b1,1'b0);
    set_vec(2,  "sc_wr_01", 1'b0,1'b0,1'b0,1'b1,8'h01, 8'h00, 1'b0,1'b1);
    set_vec(3,  "sc_rd_01", 1'b0,1'b0,1'b1,1'b0,8'h00, 8'h7F, 1'b1,1'b1);
    set_vec(4,  "sc_wr_80", 1'b0,1'b0,1'b0,1'b1,8'h80, 8'h00, 1'b0,1'b0);
    set_vec(5,  "sc_rd_80", 1'b0,1'b0,1'b1,1'b0,8'h00, 8'hFE, 1'b1,1'b0);
    set_vec(6,  "sc_wr_00", 1'b0,1'b0,1'b0,1'b1,8'h00, 8'h00, 1'b0,1'b0);
    set_vec(7,  "sc_rd_00", 1'b0,1'b0,1'b1,1'b0,8'h00, 8'h7E, 1'b1,1'b0);
    set_vec(8,  "sb_wr_c3", 1'b0,1'b1,1'b0,1'b0,8'hC3, 8'h00, 1'b0,1'b0);
    set_vec(9,  "sb_rd_c3", 1'b1,1'b0,1'b0,1'b0,8'h00, 8'hC3, 1'b1,1'b0);
    set_vec(10, "no_strobe",1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b0);

    cyc(3);
    reset = 1'b0;
    cyc(1);

    // Reset state
    chk("rst_sout", sout, 1);
    chk("rst_sck_out", sck_out, 1);
    chk("rst_sck_oe", sck_oe, 0);
    chk("rst_int", int_serial, 0);
    chk("rst_d_oe", d_oe, 0);
    rd_sb(v); chk("rst_sb", v, 8'h00);
    rd_sc(v); chk("rst_sc", v, 8'h7E);

    // Register access table
    for (int i = 0; i < 11; i++) begin
      sb_read = vecs[i].sb_rd; n_sb_write = ~vecs[i].sb_wr;
      sc_read = vecs[i].sc_rd; sc_write = vecs[i].sc_wr; d_in = vecs[i].din;
      #2;
      chk({vecs[i].name, "_oe"}, d_oe, vecs[i].exp_oe);
      if (vecs[i].exp_oe) chk({vecs[i].name, "_dout"}, d_out, vecs[i].exp_dout);
      cyc(1);
      sb_read = 1'b0; n_sb_write = 1'b1; sc_read = 1'b0; sc_write = 1'b0;
      chk({vecs[i].name, "_sck_oe"}, sck_oe, vecs[i].exp_sck_oe);
    end

    // Internal transfer of A5 with sin=1
    base = int_cnt;
    wr_sb(8'hA5); sin = 1'b1; wr_sc(8'h81);
    pat = 8'hA5;
    for (int i = 0; i < 15; i++) begin
      lfo_pulse();
      if (i % 2 == 0) begin
        chk($sformatf("int_sck_low_%0d", i), sck_out, 0);
        chk($sformatf("int_sout_bit%0d", i / 2), sout, pat[7 - i / 2]);
      end else begin
        chk($sformatf("int_sck_high_%0d", i), sck_out, 1);
      end
    end
    chk("int_no_early_irq", int_cnt - base, 0);
    lfo_16384Hz = 1'b1; cyc(1);
    chk("int_irq_after_shift", int_serial, 1);
    cyc(1);
    chk("int_irq_one_clk", int_serial, 0);
    lfo_16384Hz = 1'b0; cyc(3);
    rd_sb(v); chk("int_sb_ff", v, 8'hFF);
    rd_sc(v); chk("int_sc_7f", v, 8'h7F);
    chk("int_irq_count", int_cnt - base, 1);

    // External transfer: sin pattern 3C, SB starts as C3
    base = int_cnt;
    wr_sb(8'hC3); wr_sc(8'h80);
    pat = 8'h3C;
    v = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      sin = pat[7 - i]; sck_in = 1'b0; cyc(5);
      chk($sformatf("ext_sout_bit%0d", i), sout, v[7 - i]);
      chk($sformatf("ext_sck_oe_%0d", i), sck_oe, 0);
      sck_in = 1'b1; cyc(5);
    end
    rd_sb(v); chk("ext_sb_3c", v, 8'h3C);
    rd_sc(v); chk("ext_sc_7e", v, 8'h7E);
    chk("ext_irq_count", int_cnt - base, 1);

    // Abort after 3 bits (2 shifted, third in progress)
    base = int_cnt;
    sin = 1'b1; wr_sb(8'h00); wr_sc(8'h81);
    repeat (5) lfo_pulse();
    chk("abort_sck_low_before", sck_out, 0);
    wr_sc(8'h01);
    chk("abort_sck_out", sck_out, 1);
    rd_sc(v); chk("abort_sc_7f", v, 8'h7F);
    repeat (40) lfo_pulse();
    chk("abort_no_irq", int_cnt - base, 0);
    rd_sb(v); chk("abort_sb_frozen", v, 8'h03);

    // SC write coinciding with the final shift
    base = int_cnt;
    sin = 1'b0; wr_sb(8'h00); wr_sc(8'h81);
    repeat (15) lfo_pulse();
    lfo_16384Hz = 1'b1; sc_write = 1'b1; d_in = 8'h81; cyc(1);
    sc_write = 1'b0; cyc(1);
    lfo_16384Hz = 1'b0; cyc(3);
    chk("restart_no_irq", int_cnt - base, 0);
    chk("restart_sck_high", sck_out, 1);
    sin = 1'b1;
    repeat (15) lfo_pulse();
    chk("restart_no_irq_15", int_cnt - base, 0);
    lfo_pulse();
    chk("restart_irq", int_cnt - base, 1);
    rd_sb(v); chk("restart_sb_ff", v, 8'hFF);

    // Reset mid-transfer
    base = int_cnt;
    sin = 1'b1; wr_sb(8'h00); wr_sc(8'h81);
    repeat (5) lfo_pulse();
    chk("pre_rst_sck_low", sck_out, 0);
    chk("pre_rst_sout_low", sout, 0);
    reset = 1'b1; cyc(1); reset = 1'b0;
    rd_sb(v); chk("mid_rst_sb", v, 8'h00);
    rd_sc(v); chk("mid_rst_sc", v, 8'h7E);
    chk("mid_rst_sout", sout, 1);
    chk("mid_rst_sck_out", sck_out, 1);
    chk("mid_rst_sck_oe", sck_oe, 0);
    repeat (20) lfo_pulse();
    chk("mid_rst_no_irq", int_cnt - base, 0);

    // Idle: external clock edges ignored
    base = int_cnt;
    wr_sc(8'h00); wr_sb(8'h5A);
    for (int i = 0; i < 10; i++) begin
      sin = i[0]; sck_in = 1'b0; cyc(5); sck_in = 1'b1; cyc(5);
    end
    rd_sb(v); chk("idle_sb_kept", v, 8'h5A);
    chk("idle_no_irq", int_cnt - base, 0);

    // Every interrupt exactly one clk wide
    chk("irq_total", int_cnt, 3);
    chk("irq_width", int_hi, int_cnt);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
